// File: rtl/alu_mismatch_logger_pkg.sv
// Shared types and constants for the ALU lockstep mismatch logger.
// Holds the FSM encoding, the captured-entry layout and an entry packing helper.
package alu_mismatch_logger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int ENTRY_W  = 14;

  // Entry layout, MSB first: {sel1, sel2, out1, out2, carry1, carry2}
  localparam int SEL1_LSB = 12;
  localparam int SEL2_LSB = 10;
  localparam int OUT1_LSB = 6;
  localparam int OUT2_LSB = 2;
  localparam int C1_BIT   = 1;
  localparam int C2_BIT   = 0;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [1:0] sel1,
    input logic [1:0] sel2,
    input logic [3:0] out1,
    input logic [3:0] out2,
    input logic       c1,
    input logic       c2
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[SEL1_LSB +: 2] = sel1;
    e[SEL2_LSB +: 2] = sel2;
    e[OUT1_LSB +: 4] = out1;
    e[OUT2_LSB +: 4] = out2;
    e[C1_BIT]        = c1;
    e[C2_BIT]        = c2;
    return e;
  endfunction

endpackage

// File: rtl/alu_mismatch_logger_fifo.sv
// First-word-fall-through FIFO for captured mismatch entries.
// Pointers carry an extra MSB so full and empty are told apart without a counter.
module mismatch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // When full, a simultaneous pop frees the head slot, which is the one written.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_mismatch_logger.sv
// Lockstep ALU pair checker: counts samples and mismatches, captures mismatching
// samples into a FIFO and halts logging once a programmable mismatch count is hit.
module alu_mismatch_logger
  import alu_mismatch_logger_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SCNT_W = 16,
  parameter int MCNT_W = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [MCNT_W-1:0]   thresh_i,
  input  logic                sample_i,
  input  logic [1:0]          alu_sel1_i,
  input  logic [1:0]          alu_sel2_i,
  input  logic [3:0]          alu_out1_i,
  input  logic [3:0]          alu_out2_i,
  input  logic                carry1_i,
  input  logic                carry2_i,
  input  logic [3:0]          x_i,
  input  logic                pop_i,
  output logic [ENTRY_W-1:0]  entry_o,
  output logic                entry_valid_o,
  output logic [SCNT_W-1:0]   sample_cnt_o,
  output logic [MCNT_W-1:0]   mismatch_cnt_o,
  output logic                overflow_o,
  output logic                halted_o,
  output logic                irq_o,
  output logic [1:0]          state_o
);

  // Drain handshake: entry_o is meaningful only while entry_valid_o is high; a
  // cycle with entry_valid_o && pop_i consumes the head, pop_i alone is ignored.

  state_t              state, state_n;
  logic                accept;
  logic                mism;
  logic                log_mism;
  logic [MCNT_W-1:0]   mcnt_next;
  logic                fifo_full;
  logic                fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                unused_count;
  logic [ENTRY_W-1:0]  entry_in;

  assign mism      = (x_i != 4'd0) | (carry1_i ^ carry2_i);
  assign accept    = sample_i && (state == ST_RUN) && !clear_i;
  assign log_mism  = accept && mism;
  assign mcnt_next = (mismatch_cnt_o == '1) ? mismatch_cnt_o : mismatch_cnt_o + 1'b1;
  assign entry_in  = pack_entry(alu_sel1_i, alu_sel2_i, alu_out1_i, alu_out2_i,
                                carry1_i, carry2_i);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (enable_i) state_n = ST_RUN;
      ST_RUN: begin
        if (log_mism && (thresh_i != '0) && (mcnt_next == thresh_i)) state_n = ST_HALT;
        else if (!enable_i) state_n = ST_IDLE;
      end
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_IDLE;
    endcase
    if (clear_i) state_n = ST_IDLE;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state          <= ST_IDLE;
      sample_cnt_o   <= '0;
      mismatch_cnt_o <= '0;
      overflow_o     <= 1'b0;
      irq_o          <= 1'b0;
    end else if (clear_i) begin
      state          <= ST_IDLE;
      sample_cnt_o   <= '0;
      mismatch_cnt_o <= '0;
      overflow_o     <= 1'b0;
      irq_o          <= 1'b0;
    end else begin
      state <= state_n;
      irq_o <= log_mism;
      if (accept && (sample_cnt_o != '1)) sample_cnt_o <= sample_cnt_o + 1'b1;
      if (log_mism) mismatch_cnt_o <= mcnt_next;
      if (log_mism && fifo_full && !pop_i) overflow_o <= 1'b1;
    end
  end

  assign halted_o      = (state == ST_HALT);
  assign state_o       = state;
  assign entry_valid_o = !fifo_empty;
  assign unused_count  = ^fifo_count;

  mismatch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .clear (clear_i),
    .push  (log_mism),
    .pop   (pop_i),
    .din   (entry_in),
    .dout  (entry_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_alu_mismatch_logger.sv
// Directed bench for alu_mismatch_logger: a vector table for the main stream plus
// hand-written sequences for threshold halt, full push/pop, clear and reset.
module tb_alu_mismatch_logger;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [7:0]  thresh;
  logic        sample;
  logic [1:0]  sel1, sel2;
  logic [3:0]  out1, out2, x;
  logic        c1, c2;
  logic        pop;
  logic [13:0] entry;
  logic        entry_valid;
  logic [15:0] sample_cnt;
  logic [7:0]  mismatch_cnt;
  logic        overflow;
  logic        halted;
  logic        irq;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  logic [13:0] exp_q[$];

  typedef struct {
    logic        smp;
    logic [1:0]  s1, s2;
    logic [3:0]  o1, o2, xv;
    logic        cc1, cc2;
    logic        pp;
    logic        ev;
    logic [15:0] sc;
    logic [7:0]  mc;
    logic        ir;
    logic        ov;
    logic [13:0] ent;
  } vec_t;

  vec_t vecs[14];

  alu_mismatch_logger #(.DEPTH(4), .SCNT_W(16), .MCNT_W(8)) dut (
    .wb_clk_i       (clk),
    .wb_rst_n       (rst_n),
    .enable_i       (enable),
    .clear_i        (clear),
    .thresh_i       (thresh),
    .sample_i       (sample),
    .alu_sel1_i     (sel1),
    .alu_sel2_i     (sel2),
    .alu_out1_i     (out1),
    .alu_out2_i     (out2),
    .carry1_i       (c1),
    .carry2_i       (c2),
    .x_i            (x),
    .pop_i          (pop),
    .entry_o        (entry),
    .entry_valid_o  (entry_valid),
    .sample_cnt_o   (sample_cnt),
    .mismatch_cnt_o (mismatch_cnt),
    .overflow_o     (overflow),
    .halted_o       (halted),
    .irq_o          (irq),
    .state_o        (state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] pk(input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] o, input logic [3:0] p,
                                     input logic ca, input logic cb);
    return {a, b, o, p, ca, cb};
  endfunction

  function automatic vec_t mk(input logic smp, input logic [1:0] s1, input logic [1:0] s2,
                              input logic [3:0] o1, input logic [3:0] o2, input logic [3:0] xv,
                              input logic cc1, input logic cc2, input logic pp, input logic ev,
                              input logic [15:0] sc, input logic [7:0] mc, input logic ir,
                              input logic ov, input logic [13:0] ent);
    vec_t v;
    v.smp = smp; v.s1 = s1; v.s2 = s2; v.o1 = o1; v.o2 = o2; v.xv = xv;
    v.cc1 = cc1; v.cc2 = cc2; v.pp = pp; v.ev = ev; v.sc = sc; v.mc = mc;
    v.ir = ir; v.ov = ov; v.ent = ent;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic smp, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [3:0] o1, input logic [3:0] o2, input logic [3:0] xv,
                       input logic cc1, input logic cc2, input logic pp);
    sample = smp; sel1 = s1; sel2 = s2; out1 = o1; out2 = o2; x = xv;
    c1 = cc1; c2 = cc2; pop = pp;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " entry_valid"}, {31'd0, entry_valid}, 32'd0);
    chk({tag, " sample_cnt"}, {16'd0, sample_cnt}, 32'd0);
    chk({tag, " mismatch_cnt"}, {24'd0, mismatch_cnt}, 32'd0);
    chk({tag, " overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, " halted"}, {31'd0, halted}, 32'd0);
    chk({tag, " irq"}, {31'd0, irq}, 32'd0);
    chk({tag, " state"}, {30'd0, state}, 32'd0);
  endtask

  task automatic do_clear();
    enable = 1'b0;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
  endtask

  // stimulus + scoreboard
  initial begin
    logic [13:0] f [5];
    logic [13:0] exp_e;
    int budget;

    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; thresh = 8'd0;
    idle_inputs();

    // Row layout: smp s1 s2 o1 o2 x c1 c2 pop | ev sc mc irq ovf entry
    vecs[0]  = mk(1, 0, 0, 4'h5, 4'h5, 4'h0, 0, 0, 0,  0, 1, 0, 0, 0, 14'h0);
    vecs[1]  = mk(1, 1, 1, 4'hA, 4'h8, 4'h2, 0, 0, 0,  1, 2, 1, 1, 0, 14'h16A0);
    vecs[2]  = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0,  1, 2, 1, 0, 0, 14'h16A0);
    vecs[3]  = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1,  0, 2, 1, 0, 0, 14'h0);
    vecs[4]  = mk(1, 0, 0, 4'h3, 4'h3, 4'h0, 1, 0, 0,  1, 3, 2, 1, 0, pk(0, 0, 4'h3, 4'h3, 1, 0));
    vecs[5]  = mk(1, 2, 2, 4'hF, 4'hE, 4'h1, 0, 0, 0,  1, 4, 3, 1, 0, pk(0, 0, 4'h3, 4'h3, 1, 0));
    vecs[6]  = mk(1, 3, 3, 4'h0, 4'h8, 4'h8, 0, 0, 0,  1, 5, 4, 1, 0, pk(0, 0, 4'h3, 4'h3, 1, 0));
    vecs[7]  = mk(1, 1, 0, 4'h6, 4'h2, 4'h4, 1, 1, 0,  1, 6, 5, 1, 0, pk(0, 0, 4'h3, 4'h3, 1, 0));
    vecs[8]  = mk(1, 2, 1, 4'h1, 4'h0, 4'h1, 0, 0, 0,  1, 7, 6, 1, 1, pk(0, 0, 4'h3, 4'h3, 1, 0));
    vecs[9]  = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1,  1, 7, 6, 0, 1, pk(2, 2, 4'hF, 4'hE, 0, 0));
    vecs[10] = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1,  1, 7, 6, 0, 1, pk(3, 3, 4'h0, 4'h8, 0, 0));
    vecs[11] = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1,  1, 7, 6, 0, 1, pk(1, 0, 4'h6, 4'h2, 1, 1));
    vecs[12] = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1,  0, 7, 6, 0, 1, 14'h0);
    vecs[13] = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1,  0, 7, 6, 0, 1, 14'h0);

    // reset state
    tick(); tick();
    chk_all_zero("reset");
    chk("reset entry", {18'd0, entry}, 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // sample in the enable-rising cycle is not accepted
    enable = 1'b1;
    drive(1, 0, 0, 4'h1, 4'h2, 4'h3, 0, 0, 0);
    tick();
    chk("enable_edge sample_cnt", {16'd0, sample_cnt}, 32'd0);
    chk("enable_edge state", {30'd0, state}, 32'd1);
    chk("enable_edge valid", {31'd0, entry_valid}, 32'd0);

    // table-driven stream: match, mismatch, pop, overflow, drain, empty pop
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].smp, vecs[i].s1, vecs[i].s2, vecs[i].o1, vecs[i].o2, vecs[i].xv,
            vecs[i].cc1, vecs[i].cc2, vecs[i].pp);
      tick();
      chk($sformatf("vec%0d valid", i), {31'd0, entry_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d sample_cnt", i), {16'd0, sample_cnt}, {16'd0, vecs[i].sc});
      chk($sformatf("vec%0d mismatch_cnt", i), {24'd0, mismatch_cnt}, {24'd0, vecs[i].mc});
      chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].ir});
      chk($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ov});
      if (vecs[i].ev)
        chk($sformatf("vec%0d entry", i), {18'd0, entry}, {18'd0, vecs[i].ent});
    end
    idle_inputs();

    // clear zeroes everything; a sample in the clear cycle is discarded
    enable = 1'b1;
    drive(1, 0, 0, 4'h1, 4'h0, 4'h1, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    enable = 1'b0;
    idle_inputs();
    chk_all_zero("clear1");

    // threshold halt at 3 mismatches, 4th ignored, pop still works in HALT
    thresh = 8'd3;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), 2'(i), 4'(i), 4'hF, 4'(i) ^ 4'hF, 0, 0, 0);
      tick();
      if (i == 2) begin
        chk("thresh halted_rise", {31'd0, halted}, 32'd1);
        chk("thresh mcnt_at3", {24'd0, mismatch_cnt}, 32'd3);
        chk("thresh irq_3rd", {31'd0, irq}, 32'd1);
      end
    end
    chk("thresh mcnt_hold", {24'd0, mismatch_cnt}, 32'd3);
    chk("thresh scnt_hold", {16'd0, sample_cnt}, 32'd3);
    chk("thresh irq_4th", {31'd0, irq}, 32'd0);
    chk("thresh state", {30'd0, state}, 32'd2);
    chk("thresh head", {18'd0, entry}, {18'd0, pk(0, 0, 4'h0, 4'hF, 0, 0)});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    idle_inputs();
    chk("halt pop head", {18'd0, entry}, {18'd0, pk(1, 1, 4'h1, 4'hF, 0, 0)});
    chk("halt still", {31'd0, halted}, 32'd1);
    enable = 1'b0;
    tick();
    chk("halt ignores enable", {30'd0, state}, 32'd2);
    do_clear();
    thresh = 8'd0;
    chk_all_zero("clear2");

    // full FIFO with simultaneous push and pop
    f[0] = pk(0, 1, 4'h1, 4'h2, 0, 0);
    f[1] = pk(1, 2, 4'h3, 4'h4, 0, 1);
    f[2] = pk(2, 3, 4'h5, 4'h6, 1, 0);
    f[3] = pk(3, 0, 4'h7, 4'h8, 0, 0);
    f[4] = pk(3, 3, 4'h9, 4'hB, 1, 1);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, f[i][13:12], f[i][11:10], f[i][9:6], f[i][5:2], f[i][9:6] ^ f[i][5:2],
            f[i][1], f[i][0], (i == 4));
      if (i > 0) exp_q.push_back(f[i]);
      tick();
    end
    idle_inputs();
    chk("pushpop overflow", {31'd0, overflow}, 32'd0);
    chk("pushpop mcnt", {24'd0, mismatch_cnt}, 32'd5);
    budget = 0;
    while (entry_valid && budget < 8) begin
      if (exp_q.size() == 0) begin
        chk("pushpop extra entry", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("pushpop drain", {18'd0, entry}, {18'd0, exp_e});
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
      budget++;
    end
    chk("pushpop drained_all", exp_q.size(), 32'd0);
    chk("pushpop empty", {31'd0, entry_valid}, 32'd0);
    drive(1, 0, 0, 4'h1, 4'h0, 4'h1, 0, 0, 0);
    tick();
    idle_inputs();
    do_clear();
    chk_all_zero("clear3");

    // asynchronous reset during a sample stream
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 4'(i + 1), 4'h0, 4'(i + 1), 0, 0, 0);
      tick();
    end
    chk("prereset mcnt", {24'd0, mismatch_cnt}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    chk("async_reset entry", {18'd0, entry}, 32'd0);
    enable = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("post_reset idle scnt", {16'd0, sample_cnt}, 32'd0);
    chk("post_reset idle state", {30'd0, state}, 32'd0);
    enable = 1'b1;
    tick();
    chk("post_reset edge scnt", {16'd0, sample_cnt}, 32'd0);
    tick();
    chk("post_reset accept scnt", {16'd0, sample_cnt}, 32'd1);
    chk("post_reset accept mcnt", {24'd0, mismatch_cnt}, 32'd1);
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
